// File: rtl/vector_player_if.sv
// Control/table-load and stimulus/expected bus of the vector player.
// master = the player itself, slave = the side that loads/starts it and consumes its outputs.
interface vector_player_if #(
  parameter int IN_WIDTH   = 8,
  parameter int EXP_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                          start;
  logic [ADDR_WIDTH:0]           num_vec;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [IN_WIDTH+EXP_WIDTH-1:0] wr_data;
  logic [IN_WIDTH-1:0]           dut_in_vec;
  logic                          cmp_on;
  logic                          ctrans;
  logic [EXP_WIDTH-1:0]          exp_vec_out;
  logic                          busy;
  logic                          done;
  logic [ADDR_WIDTH:0]           vec_idx;

  modport master (
    input  start, num_vec, wr_en, wr_addr, wr_data,
    output dut_in_vec, cmp_on, ctrans, exp_vec_out, busy, done, vec_idx
  );

  modport slave (
    output start, num_vec, wr_en, wr_addr, wr_data,
    input  dut_in_vec, cmp_on, ctrans, exp_vec_out, busy, done, vec_idx
  );
endinterface

// File: rtl/vector_player.sv
// Plays a table of {stimulus, expected} pairs into a DUT and feeds the comparator,
// delaying ctrans/expected by DUT_LAT so they line up with the DUT output.
module vector_player #(
  parameter int IN_WIDTH   = 8,
  parameter int EXP_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DUT_LAT    = 0,
  parameter int GAP        = 0
) (
  input  logic           clk,
  input  logic           reset_,
  vector_player_if.master bus
);
  localparam int VW = IN_WIDTH + EXP_WIDTH;
  localparam int CW = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_e;

  logic [VW-1:0]                   mem_q [DEPTH];
  state_e                          state_q;
  logic [ADDR_WIDTH:0]             n_q, idx_q, n_d;
  logic [CW-1:0]                   cnt_q;
  logic [DUT_LAT:0]                vld_pipe_q;
  logic [DUT_LAT:0][EXP_WIDTH-1:0] exp_pipe_q;
  logic [IN_WIDTH-1:0]             dut_in_q;
  logic [EXP_WIDTH-1:0]            exp_out_q;
  logic                            busy_q, cmp_on_q, done_q;
  logic [VW-1:0]                   rd_d;
  logic                            issue_d;

  assign n_d     = (bus.num_vec > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : bus.num_vec;
  assign rd_d    = mem_q[idx_q[ADDR_WIDTH-1:0]];
  assign issue_d = (state_q == ISSUE);

  // Table survives reset; loads are only accepted while idle.
  always_ff @(posedge clk) begin
    if (bus.wr_en && state_q == IDLE) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
      dut_in_q   <= '0;
      exp_out_q  <= '0;
      busy_q     <= 1'b0;
      cmp_on_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      // Stage 0 becomes visible together with the new stimulus, so ctrans
      // from stage DUT_LAT lands exactly DUT_LAT cycles after it.
      vld_pipe_q[0] <= issue_d;
      if (issue_d) exp_pipe_q[0] <= rd_d[EXP_WIDTH-1:0];
      for (int i = 1; i <= DUT_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        exp_pipe_q[i] <= exp_pipe_q[i-1];
      end
      if (vld_pipe_q[DUT_LAT]) exp_out_q <= exp_pipe_q[DUT_LAT];

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            n_q      <= n_d;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            cmp_on_q <= 1'b1;
            state_q  <= (n_d == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          dut_in_q <= rd_d[VW-1:EXP_WIDTH];
          idx_q    <= idx_q + 1'b1;
          cnt_q    <= '0;
          if (idx_q + 1'b1 == n_q) state_q <= DRAIN;
          else if (GAP > 0)        state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CW'(GAP - 1)) begin
            cnt_q   <= '0;
            state_q <= ISSUE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          // Last token leaves the pipe and its expected value is presented.
          if (cnt_q == CW'(DUT_LAT + 1)) state_q <= DONE;
          else                           cnt_q   <= cnt_q + 1'b1;
        end
        DONE: begin
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          cmp_on_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dut_in_vec  = dut_in_q;
  assign bus.cmp_on      = cmp_on_q;
  assign bus.ctrans      = vld_pipe_q[DUT_LAT];
  assign bus.exp_vec_out = exp_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vec_idx     = idx_q;
endmodule

// File: tb/tb_vector_player.sv
// Scoreboard bench: two players (LAT0/GAP0 and LAT2/GAP3) share stimulus; a monitor
// per player pops expected vectors on ctrans and checks stimulus, timing and expected data.
module tb_vector_player;
  localparam int IW = 8;
  localparam int EW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic [IW-1:0] stim;
    logic [EW-1:0] exp;
    logic [AW:0]   k;
  } vec_t;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW:0]   num_vec = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [IW+EW-1:0] wr_data = '0;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  vec_t sb_q [2][$];
  int   done_cnt [2];
  int   done_cyc [2];
  int   ct_cnt [2];
  int   match_cnt [2];
  int   miss_cnt [2];
  logic [IW+EW-1:0] tbl [D];

  logic          busy_w [2];
  logic          cmp_on_w [2];
  logic          ctrans_w [2];
  logic          done_w [2];
  logic [IW-1:0] dut_w [2];
  logic [EW-1:0] exp_w [2];
  logic [AW:0]   idx_w [2];

  task automatic chk(input string nm, input int g, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s u%0d: got %0h expected %0h", nm, g, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int L = (g == 0) ? 0 : 2;
    localparam int G = (g == 0) ? 0 : 3;

    vector_player_if #(.IN_WIDTH(IW), .EXP_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();

    vector_player #(.IN_WIDTH(IW), .EXP_WIDTH(EW), .DEPTH(D), .ADDR_WIDTH(AW),
                    .DUT_LAT(L), .GAP(G)) u_dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
    );

    assign bus.start   = start;
    assign bus.num_vec = num_vec;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign busy_w[g]   = bus.busy;
    assign cmp_on_w[g] = bus.cmp_on;
    assign ctrans_w[g] = bus.ctrans;
    assign done_w[g]   = bus.done;
    assign dut_w[g]    = bus.dut_in_vec;
    assign exp_w[g]    = bus.exp_vec_out;
    assign idx_w[g]    = bus.vec_idx;

    // Monitor plus a tiny comparator model; the DUT is modelled as out = in - 0x70.
    initial begin
      logic [IW-1:0] prev;
      logic [EW-1:0] dout;
      int   last_chg, last_ct;
      bit   pend;
      vec_t cur;
      prev = '0; dout = '0; last_chg = 0; last_ct = 0; pend = 1'b0; cur = '0;
      done_cnt[g] = 0; done_cyc[g] = 0; ct_cnt[g] = 0; match_cnt[g] = 0; miss_cnt[g] = 0;
      forever begin
        @(negedge clk);
        if (!reset_) begin
          pend = 1'b0;
          prev = bus.dut_in_vec;
          continue;
        end
        if (bus.dut_in_vec != prev) last_chg = cyc;
        prev = bus.dut_in_vec;
        if (pend) begin
          chk("exp_vec_out", g, bus.exp_vec_out, cur.exp);
          chk("cmp_on_at_cmp", g, bus.cmp_on, 1);
          if (bus.cmp_on) begin
            if (dout == bus.exp_vec_out) match_cnt[g]++;
            else                         miss_cnt[g]++;
          end
          pend = 1'b0;
        end
        if (bus.done) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        if (bus.ctrans) begin
          ct_cnt[g]++;
          if (sb_q[g].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ctrans_unexpected u%0d: got ctrans with empty scoreboard", g);
          end else begin
            cur = sb_q[g].pop_front();
            if (cur.k == 0) begin
              match_cnt[g] = 0;
              miss_cnt[g]  = 0;
            end else begin
              chk("ctrans_spacing", g, cyc - last_ct, G + 1);
            end
            chk("stim_at_ctrans", g, bus.dut_in_vec, cur.stim);
            chk("ctrans_latency", g, cyc - last_chg, L);
            chk("vec_idx_at_ctrans", g, bus.vec_idx, int'(cur.k) + 1);
            last_ct = cyc;
            dout    = bus.dut_in_vec - 8'h70;
            pend    = 1'b1;
          end
        end
      end
    end
  end

  task automatic wr(input int a, input logic [IW+EW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    tbl[a] = d;
  endtask

  task automatic run(input int nv, input bit inject);
    int n, t_s, lat;
    int d0 [2];
    int c0 [2];
    n = (nv > D) ? D : nv;
    for (int g = 0; g < 2; g++) begin
      d0[g] = done_cnt[g];
      c0[g] = ct_cnt[g];
      for (int k = 0; k < n; k++)
        sb_q[g].push_back('{stim: tbl[k][IW+EW-1:EW], exp: tbl[k][EW-1:0], k: (AW+1)'(k)});
    end
    num_vec = (AW+1)'(nv);
    start   = 1'b1;
    t_s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (inject) begin
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; num_vec = 5'd2; wr_en = 1'b1; wr_addr = '0; wr_data = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
    end
    for (int t = 0; t < 400; t++) begin
      if (done_cnt[0] > d0[0] && done_cnt[1] > d0[1]) break;
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      lat = (n == 0) ? 2 : 5 + (g == 0 ? 0 : 2) + (n - 1) * (g == 0 ? 1 : 4);
      chk("done_pulses", g, done_cnt[g] - d0[g], 1);
      chk("done_latency", g, done_cyc[g] - t_s, lat);
      chk("ctrans_count", g, ct_cnt[g] - c0[g], n);
      chk("sb_leftover", g, sb_q[g].size(), 0);
      chk("vec_idx_final", g, idx_w[g], n);
      chk("busy_after", g, busy_w[g], 0);
      chk("cmp_on_after", g, cmp_on_w[g], 0);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int d0 [2];
    repeat (3) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", g, busy_w[g], 0);
      chk("rst_cmp_on", g, cmp_on_w[g], 0);
      chk("rst_ctrans", g, ctrans_w[g], 0);
      chk("rst_done", g, done_w[g], 0);
      chk("rst_dut_in", g, dut_w[g], 0);
      chk("rst_exp_out", g, exp_w[g], 0);
      chk("rst_vec_idx", g, idx_w[g], 0);
    end
    reset_ = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < D; i++) wr(i, {8'hA0 + 8'(i), 8'h30 + 8'(i)});

    // four clean vectors
    run(4, 1'b0);
    for (int g = 0; g < 2; g++) begin
      chk("t1_match", g, match_cnt[g], 4);
      chk("t1_miss", g, miss_cnt[g], 0);
    end

    // three vectors, checks vec_idx end value and spacing
    run(3, 1'b0);

    // corrupted expected value on entry 1
    wr(1, 16'hA1FF);
    run(4, 1'b0);
    for (int g = 0; g < 2; g++) begin
      chk("t3_match", g, match_cnt[g], 3);
      chk("t3_miss", g, miss_cnt[g], 1);
    end
    wr(1, 16'hA131);

    // empty run and clamped run
    run(0, 1'b0);
    run(20, 1'b0);

    // reset on the second issue cycle
    for (int g = 0; g < 2; g++) d0[g] = done_cnt[g];
    num_vec = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      chk("t5_busy", g, busy_w[g], 0);
      chk("t5_cmp_on", g, cmp_on_w[g], 0);
      chk("t5_ctrans", g, ctrans_w[g], 0);
    end
    @(posedge clk); #1;
    reset_ = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) chk("t5_no_done", g, done_cnt[g] - d0[g], 0);
    run(4, 1'b0);

    // start and write while busy are ignored; entry 0 must still hold its old pair
    run(4, 1'b1);
    run(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
